line_fill_mem: RTL and testbench

// - Backing-memory responder on the far side of cache_mem's miss path. Serves whole-line refills
//   (read bursts) and dirty-line writebacks (write bursts) requested by the cache controller.
// - One request = one cache line = WORDS_PER_LINE beats of DATA_WIDTH.
// - Fixed, programmable access latency before the read data starts.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/lf_mem_array.sv | 33 +++
 rtl/line_fill_mem.sv | 152 +++++++++++++++
 tb/tb_line_fill_mem.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Brief  : Shared line geometry, index types and refill/writeback FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

    localparam int DATA_WIDTH_DEF   = 32;
    localparam int OFFSET_WIDTH_DEF = 6;
    localparam int MEM_WORDS_DEF    = 4096;

    localparam int WORDS_PER_LINE = (2 ** OFFSET_WIDTH_DEF) / (DATA_WIDTH_DEF / 8);
    localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
    localparam int MEM_AW         = $clog2(MEM_WORDS_DEF);

    typedef logic [MEM_AW-1:0]        word_idx_t;
    typedef logic [MEM_AW-BEAT_W-1:0] line_idx_t;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LATENCY     = 3'd1,
        READ_BURST  = 3'd2,
        WRITE_BURST = 3'd3,
        WB_DONE     = 3'd4
    } lf_state_e;

endpackage

`default_nettype wire

// File: rtl/lf_mem_array.sv
// ============================================================================
// Module : lf_mem_array
// Brief  : Line-fill backing store, synchronous write and asynchronous read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lf_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int AW         = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // Contents survive reset by design, so this array has no reset term.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/line_fill_mem.sv
// ============================================================================
// Module : line_fill_mem
// Brief  : Backing-memory responder serving whole-line refills and writebacks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module line_fill_mem
    import cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int OFFSET_WIDTH  = 6,
    parameter int MEM_WORDS     = 4096,
    parameter int READ_LATENCY  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_done,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_last
);

    localparam int LINE_WORDS = (2 ** OFFSET_WIDTH) / (DATA_WIDTH / 8);
    localparam int BEAT_BITS  = $clog2(LINE_WORDS);
    localparam int MEM_ABITS  = $clog2(MEM_WORDS);
    localparam int BYTE_SH    = $clog2(DATA_WIDTH / 8);
    localparam int LINE_LSB   = BYTE_SH + BEAT_BITS;
    localparam int LINE_W     = MEM_ABITS - BEAT_BITS;
    localparam int LAT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

    lf_state_e              state_q, state_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [BEAT_BITS-1:0]   beat_q, beat_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic                   init_q;
    logic                   mem_we;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   addr_unused;

    // Only the in-range line index bits of req_addr select storage.
    assign addr_unused = ^req_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        beat_d    = beat_q;
        line_d    = line_q;
        mem_we    = 1'b0;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        wr_done   = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        rd_data   = '0;
        case (state_q)
            IDLE: begin
                // init_q holds off acceptance until the first edge after reset release.
                req_ready = init_q;
                if (req_valid && init_q) begin
                    line_d = req_addr[LINE_LSB +: LINE_W];
                    beat_d = '0;
                    if (req_write) begin
                        state_d = WRITE_BURST;
                    end else begin
                        state_d = LATENCY;
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                    end
                end
            end
            LATENCY: begin
                if (lat_q == '0) begin
                    state_d = READ_BURST;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            READ_BURST: begin
                rd_valid = 1'b1;
                rd_data  = mem_rdata;
                rd_last  = (beat_q == LAST_BEAT);
                if (rd_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_BITS'(1);
                    end
                end
            end
            WRITE_BURST: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_we = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = WB_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_BITS'(1);
                    end
                end
            end
            WB_DONE: begin
                wr_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    lf_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .AW         (MEM_ABITS)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  ({line_q, beat_q}),
        .wdata_i (wr_data),
        .rdata_o (mem_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_line_fill_mem.sv
// ============================================================================
// Module : tb_line_fill_mem
// Brief  : Self-checking bench for line_fill_mem against a word-array model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_line_fill_mem;

    localparam int WPL = 16;
    localparam int LAT = 4;
    localparam int MW  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        wr_done;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;

    logic [31:0] model [MW];
    logic [31:0] wbuf  [WPL];
    int          lines [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    line_fill_mem #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .OFFSET_WIDTH  (6),
        .MEM_WORDS     (MW),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word index of beat 0 of the line holding a byte address, wrapped into MW.
    function automatic int word_base(input logic [31:0] addr);
        return int'(((addr / 4) / WPL * WPL) % MW);
    endfunction

    function automatic logic [31:0] rand_addr(input int line);
        logic [31:0] a;
        a = ($urandom << 14) | (32'(line) << 6) | 32'($urandom_range(0, 63));
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (!req_ready && c < 100) begin
            tick();
            c++;
        end
        check("idle_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input int max_gap, input bit fixed_gap);
        int base  = word_base(addr);
        bit early = 1'b0;
        bit bad   = 1'b0;
        int gap;
        wait_idle();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < WPL; b++) begin
            gap = fixed_gap ? max_gap : int'($urandom_range(0, max_gap));
            repeat (gap) begin
                if (wr_done) early = 1'b1;
                tick();
            end
            wr_valid = 1'b1;
            wr_data  = wbuf[b];
            if (!wr_ready) bad = 1'b1;
            if (wr_done) early = 1'b1;
            tick();
            wr_valid = 1'b0;
            model[base + b] = wbuf[b];
        end
        check("wb_ready", 32'(bad), 32'd0);
        check("wb_no_early_done", 32'(early), 32'd0);
        check("wb_done_pulse", 32'(wr_done), 32'd1);
        tick();
        check("wb_done_end", {30'd0, wr_done, req_ready}, 32'd1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic do_read(input logic [31:0] addr, input int mode);
        int base  = word_base(addr);
        int cyc   = 0;
        int beat  = 0;
        int k     = 0;
        logic [3:0] pat = 4'b1001;
        logic rdy;
        wait_idle();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        while (!rd_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("rd_latency", 32'(cyc), 32'(LAT));
        while (beat < WPL && k < 400) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = pat[k % 4];
            else                rdy = 1'($urandom_range(0, 1));
            rd_ready = rdy;
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", rd_data, model[base + beat]);
            check("rd_last", 32'(rd_last), 32'(beat == WPL - 1));
            tick();
            if (rdy) beat++;
            k++;
        end
        rd_ready = 1'b0;
        check("rd_beats", 32'(beat), 32'(WPL));
        check("rd_end_idle", {30'd0, rd_valid, req_ready}, 32'd1);
    endtask

    initial begin
        int line;
        int base;
        int c;

        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_valids", {28'd0, wr_ready, wr_done, rd_valid, rd_last}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        check("rel_req_ready_same", 32'(req_ready), 32'd0);
        tick();
        check("rel_req_ready_next", 32'(req_ready), 32'd1);

        for (int i = 0; i < WPL; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(32'h0000_0040, 0, 1'b1);
        lines.push_back(1);
        do_read(32'h0000_0040, 0);
        do_read(32'h0000_0040, 1);
        do_read(32'h0000_007C, 0);
        do_read(32'h0001_0040, 0);

        for (int i = 0; i < WPL; i++) wbuf[i] = $urandom;
        do_write(32'h0000_1200, 2, 1'b1);
        lines.push_back(72);
        do_read(32'h0000_1200, 2);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                line = int'($urandom_range(0, 255));
                for (int i = 0; i < WPL; i++) wbuf[i] = $urandom;
                do_write(rand_addr(line), 2, 1'b0);
                lines.push_back(line);
            end else begin
                line = lines[$urandom_range(0, lines.size() - 1)];
                do_read(rand_addr(line), 2);
            end
        end

        base = word_base(32'h0000_0040);
        wait_idle();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0040;
        tick();
        req_valid = 1'b0;
        c = 0;
        while (!rd_valid && c < 50) begin
            tick();
            c++;
        end
        rd_ready = 1'b1;
        repeat (5) tick();
        rd_ready = 1'b0;
        check("pre_rst_beat5", rd_data, model[base + 5]);
        rst_n = 1'b0;
        #1;
        check("rst_async_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_async_rd_data", rd_data, 32'd0);
        tick();
        tick();
        check("rst_hold_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_rel_req_ready", 32'(req_ready), 32'd1);
        do_read(32'h0000_0040, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
